// File: rtl/pe_k_skew_feeder_if.sv
// Bundle of the k-vector input handshake and the skewed lane outputs of pe_k_skew_feeder.
//   WIDTH : bit width of one k element
//   S     : number of array rows (elements per k-vector)
// Signals:
//   i_vld / i_rdy / i_k / i_last : k-vector input handshake (master drives vld/k/last)
//   o_k / o_k_vld                : per-row skewed k lanes and their valid flags
//   o_frame_done                 : pulse when the last vector of a frame leaves lane S-1
//   o_busy                       : FIFO or skew pipeline still holds data
// Modports: master = vector source / observer, slave = the feeder itself.
interface pe_k_skew_feeder_if #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned S     = 3
);
  logic               i_vld;
  logic               i_rdy;
  logic [S*WIDTH-1:0] i_k;
  logic               i_last;
  logic [S*WIDTH-1:0] o_k;
  logic [S-1:0]       o_k_vld;
  logic               o_frame_done;
  logic               o_busy;

  modport master (
    output i_vld, i_k, i_last,
    input  i_rdy, o_k, o_k_vld, o_frame_done, o_busy
  );

  modport slave (
    input  i_vld, i_k, i_last,
    output i_rdy, o_k, o_k_vld, o_frame_done, o_busy
  );
endinterface

// File: rtl/pe_k_skew_feeder.sv
// Left-edge k injector for an S-row systolic PE array. Whole k-vectors are accepted over
// valid/ready into a DEPTH-entry FIFO, popped at most one per cycle, and fanned out onto
// S lanes with a diagonal skew: lane r presents element r of the vector popped at cycle t
// in cycle t+1+r. Cycles without a pop inject zero bubbles (data 0, valid 0).
// Ports:
//   clk  : clock
//   rstn : asynchronous active-low reset; discards buffered and in-flight vectors
//   bus  : pe_k_skew_feeder_if.slave (input handshake, skewed lanes, frame_done, busy)
// Optional feature:
//   PE_FEEDER_FLUSH_EN : when defined, each last-of-frame pop is followed by S-1 cycles with
//                        no pops so consecutive frames never overlap inside the array.
//                        When undefined, frames stream back-to-back.
module pe_k_skew_feeder #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned S     = 3,
  parameter int unsigned DEPTH = 4
) (
  input logic                 clk,
  input logic                 rstn,
  pe_k_skew_feeder_if.slave   bus
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = AW + 1;
  localparam int unsigned VW = S * WIDTH;

`ifdef PE_FEEDER_FLUSH_EN
  typedef enum logic [1:0] {StIdle, StStream, StFlush} state_e;
  localparam int unsigned FW = $clog2(S) + 1;
  logic [FW-1:0] flush_cnt_q, flush_cnt_d;
`else
  typedef enum logic [0:0] {StIdle, StStream} state_e;
`endif

  state_e state_q, state_d;

  // FIFO: entry = {last, k-vector}
  logic [VW:0]    mem [DEPTH];
  logic [AW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]  count_q, count_d;
  logic           push, pop;
  logic [VW:0]    head;
  logic           head_last;
  logic [VW-1:0]  head_k;

  // Skew pipeline
  logic [VW-1:0]  lane_k;
  logic [S-1:0]   lane_vld;
  logic [S-1:0]   lane_busy;
  logic [S-1:0]   last_q;

  assign bus.i_rdy = (count_q < CW'(DEPTH));
  assign push      = bus.i_vld & bus.i_rdy;
  // Pop only from registered count, so a vector pushed into an empty FIFO waits a cycle.
  assign pop       = (state_q == StStream) && (count_q != '0);

  assign head      = mem[rd_ptr_q];
  assign head_last = head[VW];
  assign head_k    = head[VW-1:0];

  always_comb begin
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_q] <= {bus.i_last, bus.i_k};
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_d;
    end
  end

  // FSM
  always_comb begin
    state_d = state_q;
`ifdef PE_FEEDER_FLUSH_EN
    flush_cnt_d = flush_cnt_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (count_d != '0) state_d = StStream;
      end
      StStream: begin
`ifdef PE_FEEDER_FLUSH_EN
        if (pop && head_last) begin
          state_d     = StFlush;
          flush_cnt_d = FW'(S - 1);
        end else if (count_d == '0) begin
          state_d = StIdle;
        end
`else
        if (count_d == '0) state_d = StIdle;
`endif
      end
`ifdef PE_FEEDER_FLUSH_EN
      StFlush: begin
        // Counter value 1 marks the final bubble cycle; decide where to go from there.
        if (flush_cnt_q <= FW'(1)) begin
          state_d = (count_d != '0) ? StStream : StIdle;
        end else begin
          flush_cnt_d = flush_cnt_q - FW'(1);
        end
      end
`endif
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= StIdle;
`ifdef PE_FEEDER_FLUSH_EN
      flush_cnt_q <= '0;
`endif
    end else begin
      state_q <= state_d;
`ifdef PE_FEEDER_FLUSH_EN
      flush_cnt_q <= flush_cnt_d;
`endif
    end
  end

  // Lane r is an (r+1)-deep shift register; stage 0 loads element r on a pop, else a bubble.
  for (genvar r = 0; r < S; r++) begin : g_lane
    localparam int unsigned L = r + 1;
    logic [WIDTH-1:0] dat_q [L];
    logic [L-1:0]     vld_q;

    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        vld_q <= '0;
        for (int i = 0; i < L; i++) dat_q[i] <= '0;
      end else begin
        vld_q    <= (vld_q << 1) | L'(pop);
        dat_q[0] <= pop ? head_k[r*WIDTH +: WIDTH] : '0;
        for (int i = 1; i < L; i++) dat_q[i] <= dat_q[i-1];
      end
    end

    assign lane_k[r*WIDTH +: WIDTH] = dat_q[L-1];
    assign lane_vld[r]              = vld_q[L-1];
    assign lane_busy[r]             = |vld_q;
  end

  // Last flag travels alongside lane S-1 so frame_done coincides with its final element.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      last_q <= '0;
    end else begin
      last_q <= (last_q << 1) | S'(pop & head_last);
    end
  end

  assign bus.o_k          = lane_k;
  assign bus.o_k_vld      = lane_vld;
  assign bus.o_frame_done = last_q[S-1];
  assign bus.o_busy       = (count_q != '0) | (|lane_busy);

endmodule

// File: tb/tb_pe_k_skew_feeder.sv
module tb_pe_k_skew_feeder;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned S     = 3;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned VW    = S * WIDTH;
  localparam int unsigned EW    = VW + S + 3;
`ifdef PE_FEEDER_FLUSH_EN
  localparam bit FLUSH = 1'b1;
`else
  localparam bit FLUSH = 1'b0;
`endif

  typedef struct {
    logic [VW-1:0] k;
    bit            last;
  } vec_t;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  pe_k_skew_feeder_if #(.WIDTH(WIDTH), .S(S)) bus ();

  pe_k_skew_feeder #(.WIDTH(WIDTH), .S(S), .DEPTH(DEPTH)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  // Reference model: FIFO contents plus per-cycle expected outputs keyed by cycle number.
  vec_t           q[$];
  logic [VW-1:0]  exp_k [int];
  logic [S-1:0]   exp_v [int];
  bit             exp_d [int];
  bit             exp_p [int];
  int             cyc;
  int             block_until;
  int             n_checks;
  int             n_fail;

  function automatic logic [VW-1:0] rnd_k();
    logic [VW-1:0] k;
    for (int i = 0; i < S; i++) k[i*WIDTH +: WIDTH] = $urandom;
    return k;
  endfunction

  function automatic logic [EW-1:0] expected(input int c);
    logic [VW-1:0] k;
    logic [S-1:0]  v;
    bit            d, b, rdy;
    k   = exp_k.exists(c) ? exp_k[c] : '0;
    v   = exp_v.exists(c) ? exp_v[c] : '0;
    d   = exp_d.exists(c);
    b   = (q.size() != 0) || exp_p.exists(c);
    rdy = (q.size() < DEPTH);
    return {k, v, d, b, rdy};
  endfunction

  function automatic logic [EW-1:0] observed();
    return {bus.o_k, bus.o_k_vld, bus.o_frame_done, bus.o_busy, bus.i_rdy};
  endfunction

  task automatic model_reset();
    q.delete();
    exp_k.delete();
    exp_v.delete();
    exp_d.delete();
    exp_p.delete();
    cyc         = 0;
    block_until = 0;
  endtask

  // Applies inputs for the current cycle, advances the model, moves to the next negedge.
  task automatic drive(input bit vld, input logic [VW-1:0] k, input bit last);
    bit            do_pop, do_push;
    vec_t          v;
    logic [VW-1:0] tk;
    logic [S-1:0]  tv;
    bus.i_vld  = vld;
    bus.i_k    = k;
    bus.i_last = last;
    do_pop  = (q.size() > 0) && (cyc >= block_until);
    do_push = vld && (q.size() < DEPTH);
    if (do_pop) begin
      v = q.pop_front();
      for (int r = 0; r < S; r++) begin
        tk = exp_k.exists(cyc + 1 + r) ? exp_k[cyc + 1 + r] : '0;
        tv = exp_v.exists(cyc + 1 + r) ? exp_v[cyc + 1 + r] : '0;
        tk[r*WIDTH +: WIDTH] = v.k[r*WIDTH +: WIDTH];
        tv[r] = 1'b1;
        exp_k[cyc + 1 + r] = tk;
        exp_v[cyc + 1 + r] = tv;
      end
      for (int j = 1; j <= S; j++) exp_p[cyc + j] = 1'b1;
      if (v.last) begin
        exp_d[cyc + S] = 1'b1;
        if (FLUSH) block_until = cyc + S;
      end
    end
    if (do_push) begin
      v.k    = k;
      v.last = last;
      q.push_back(v);
    end
    @(negedge clk);
    cyc++;
  endtask

  task automatic test_reset();
    rstn       = 1'b0;
    bus.i_vld  = 1'b0;
    bus.i_k    = '0;
    bus.i_last = 1'b0;
    #1;
    if (observed() !== EW'(1)) begin
      n_fail++;
      $display("FAIL reset_hold got=%h exp=%h", observed(), EW'(1));
    end
    n_checks++;
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    model_reset();
    if (observed() !== expected(cyc)) begin
      n_fail++;
      $display("FAIL reset_release got=%h exp=%h", observed(), expected(cyc));
    end
    n_checks++;
  endtask

  task automatic test_single();
    int t0;
    int done_at;
    t0      = cyc;
    done_at = -1;
    drive(1'b1, {32'd3, 32'd2, 32'd1}, 1'b1);
    for (int i = 0; i < 9; i++) begin
      if (observed() !== expected(cyc)) begin
        n_fail++;
        $display("FAIL single cyc=%0d got=%h exp=%h", cyc, observed(), expected(cyc));
      end
      n_checks++;
      if (bus.o_frame_done && done_at < 0) done_at = cyc - t0;
      drive(1'b0, rnd_k(), 1'b0);
    end
    if (done_at !== 4) begin
      n_fail++;
      $display("FAIL single_done_cycle got=%0d exp=4", done_at);
    end
    n_checks++;
  endtask

  task automatic test_burst();
    int  accepted;
    int  guard;
    bit  acc;
    accepted = 0;
    guard    = 0;
    while (accepted < 6 && guard < 50) begin
      acc = (q.size() < DEPTH);
      drive(1'b1, rnd_k(), (accepted == 2));
      if (acc) accepted++;
      guard++;
      if (observed() !== expected(cyc)) begin
        n_fail++;
        $display("FAIL burst cyc=%0d got=%h exp=%h", cyc, observed(), expected(cyc));
      end
      n_checks++;
    end
    if (accepted != 6) begin
      n_fail++;
      $display("FAIL burst_timeout got=%0d accepted exp=6", accepted);
    end
    n_checks++;
    for (int i = 0; i < 20; i++) begin
      drive(1'b0, rnd_k(), 1'b0);
      if (observed() !== expected(cyc)) begin
        n_fail++;
        $display("FAIL burst_drain cyc=%0d got=%h exp=%h", cyc, observed(), expected(cyc));
      end
      n_checks++;
    end
  endtask

  task automatic test_stream();
    int run;
    int best;
    run  = 0;
    best = 0;
    for (int i = 0; i < 16; i++) begin
      drive(i < 4, rnd_k(), 1'b0);
      if (observed() !== expected(cyc)) begin
        n_fail++;
        $display("FAIL stream cyc=%0d got=%h exp=%h", cyc, observed(), expected(cyc));
      end
      n_checks++;
      run  = bus.o_k_vld[0] ? run + 1 : 0;
      best = (run > best) ? run : best;
    end
    if (best !== 4) begin
      n_fail++;
      $display("FAIL stream_rate got=%0d consecutive lane0 vectors exp=4", best);
    end
    n_checks++;
  endtask

  task automatic test_back_to_back();
    int a0;
    int b0;
    a0 = -1;
    b0 = -1;
    for (int i = 0; i < 16; i++) begin
      drive(i < 2, rnd_k(), (i == 0));
      if (observed() !== expected(cyc)) begin
        n_fail++;
        $display("FAIL b2b cyc=%0d got=%h exp=%h", cyc, observed(), expected(cyc));
      end
      n_checks++;
      if (bus.o_k_vld[0]) begin
        if (a0 < 0) a0 = cyc;
        else if (b0 < 0) b0 = cyc;
      end
    end
    if ((b0 - a0) !== (FLUSH ? int'(S) : 1)) begin
      n_fail++;
      $display("FAIL b2b_gap got=%0d exp=%0d", b0 - a0, FLUSH ? int'(S) : 1);
    end
    n_checks++;
  endtask

  task automatic test_gaps();
    for (int i = 0; i < 16; i++) begin
      drive((i == 0) || (i == 5), rnd_k(), (i == 5));
      if (observed() !== expected(cyc)) begin
        n_fail++;
        $display("FAIL gaps cyc=%0d got=%h exp=%h", cyc, observed(), expected(cyc));
      end
      n_checks++;
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      drive(i < 380 && $urandom_range(0, 9) < 6, rnd_k(), $urandom_range(0, 3) == 0);
      if (observed() !== expected(cyc)) begin
        n_fail++;
        $display("FAIL random cyc=%0d got=%h exp=%h", cyc, observed(), expected(cyc));
      end
      n_checks++;
    end
  endtask

  task automatic test_reset_midstream();
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, rnd_k(), (i == 3));
      if (observed() !== expected(cyc)) begin
        n_fail++;
        $display("FAIL pre_reset cyc=%0d got=%h exp=%h", cyc, observed(), expected(cyc));
      end
      n_checks++;
    end
    bus.i_vld = 1'b0;
    #2;
    rstn = 1'b0;
    #1;
    if (observed() !== EW'(1)) begin
      n_fail++;
      $display("FAIL midstream_reset got=%h exp=%h", observed(), EW'(1));
    end
    n_checks++;
    @(negedge clk);
    rstn = 1'b1;
    model_reset();
    for (int i = 0; i < 12; i++) begin
      drive(i == 2, rnd_k(), 1'b1);
      if (observed() !== expected(cyc)) begin
        n_fail++;
        $display("FAIL post_reset cyc=%0d got=%h exp=%h", cyc, observed(), expected(cyc));
      end
      n_checks++;
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    model_reset();
    @(negedge clk);
    test_reset();
    test_single();
    test_burst();
    test_stream();
    test_back_to_back();
    test_gaps();
    test_random();
    test_reset_midstream();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
